sipo_loader: RTL and testbench
==============================

SIPO_LOADER -- requirements
Module: sipo_loader

Interface
REQ-001 Parameter n, default 4: parallel word width; the block SHALL support n >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first serial bit lands in Q[n-1]; 0 means it lands in Q[0].
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begins a new frame; sampled on clk.
REQ-006 sin  input  1  serial data bit.
REQ-007 sin_valid  input  1  sin carries a valid bit this cycle.
REQ-008 Q  output  n  assembled parallel word; feeds the downstream register's I input.
REQ-009 load  output  1  one-cycle strobe; feeds the downstream register's load input.
REQ-010 busy  output  1  high while a frame is being collected (state SHIFT).
REQ-011 abort  output  1  one-cycle pulse when an in-progress frame is discarded.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and LOAD.
REQ-013 IDLE -> SHIFT on a clk edge with start=1; the bit count SHALL clear to 0 and the shift register SHALL clear to 0.
REQ-014 In SHIFT, each edge with sin_valid=1 SHALL shift sin into the shift register in MSB_FIRST order and increment the count by 1.
REQ-015 In SHIFT, an edge with sin_valid=0 SHALL hold the count and the shift register; gaps between bits are unlimited.
REQ-016 On the edge that captures bit n, the FSM SHALL go SHIFT -> LOAD, Q SHALL update to the full word and load SHALL go to 1, all on that same edge.
REQ-017 load SHALL be 1 only while in LOAD, which lasts exactly one cycle; Q SHALL therefore be stable and valid whenever load=1.
REQ-018 LOAD -> IDLE by default; LOAD -> SHIFT if start=1 in LOAD, giving back-to-back frames with no dead cycle.
REQ-019 start=1 while in SHIFT SHALL discard the partial frame, clear the count and shift register, and stay in SHIFT.
REQ-020 In that restart case, abort SHALL pulse for one cycle and Q and load SHALL be unaffected.
REQ-021 If start=1 and sin_valid=1 on the same SHIFT edge, start SHALL win and the bit SHALL be dropped.
REQ-022 sin_valid SHALL be ignored in IDLE and LOAD.
REQ-023 Q SHALL hold its last loaded word between frames.
REQ-024 The count SHALL be ceil(log2(n+1)) bits wide and SHALL never exceed n (no wrap-around).

Reset
REQ-025 reset=1 SHALL immediately force: state IDLE, count 0, shift register 0, Q 0, load 0, busy 0, abort 0.
REQ-026 reset asserted mid-frame SHALL discard the partial frame without a load pulse or an abort pulse.
REQ-027 After reset deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE, SHIFT, LOAD) and the count-width calculation.
REQ-029 The bit counter SHALL be a sub-module, bit_counter, with clear, increment-enable and count output, parameterised by n.
REQ-030 The block SHALL connect directly to register_load-style consumers: Q to I, load to load, with the same clk.

Verification
REQ-031 n=4, MSB_FIRST=1: start, then bits 1,0,1,1 on consecutive valid cycles -> Q=4'b1011 with load=1 for exactly the one cycle after the 4th-bit edge.
REQ-032 n=4, MSB_FIRST=0: bits 1,0,1,1 -> Q=4'b1101; busy high from the edge after start until the 4th-bit edge.
REQ-033 Bits with 0-3 idle sin_valid=0 cycles inserted between them -> same Q as the gap-free case, with load delayed by the total number of gap cycles.
REQ-034 Restart after 2 bits, then 4 bits 0,1,1,0 -> abort pulses once, then Q=4'b0110, with no load pulse for the aborted frame.
REQ-035 reset asserted after 3 bits -> all outputs 0 immediately; a following full frame loads correctly.
REQ-036 start held during LOAD with two consecutive frames 1111 then 0001 -> two load pulses separated by exactly 4 valid cycles, giving Q=1111 then Q=0001.

Source files
------------

// File: rtl/sipo_loader_pkg.sv
// Shared definitions for the serial-in / parallel-out loader: FSM encoding
// and the width of the bit counter.
package sipo_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Counter must hold values 0..w inclusive, so it needs ceil(log2(w+1)) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit counter for the SIPO loader: synchronous clear, increment enable,
// saturates at n so it can never wrap.
module bit_counter
    import sipo_loader_pkg::*;
#(
    parameter  int n  = 4,
    localparam int CW = cnt_width(n)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] MAX_CNT = CW'(n);

    logic [CW-1:0] r_count;

    // Count valid bits of the current frame; clear has priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_CNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sipo_loader.sv
// Serial-in / parallel-out loader. Collects n valid serial bits per frame
// and presents the word on Q with a one-cycle load strobe, ready to drive a
// register_load-style consumer directly (Q -> I, load -> load).
module sipo_loader
    import sipo_loader_pkg::*;
#(
    parameter int n         = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sin,
    input  logic         sin_valid,
    output logic [n-1:0] Q,
    output logic         load,
    output logic         busy,
    output logic         abort
);

    localparam int CW = cnt_width(n);

    state_t        r_state;
    logic [n-1:0]  r_sr;
    logic [n-1:0]  r_q;
    logic          r_load;
    logic          r_busy;
    logic          r_abort;

    logic [CW-1:0] w_count;
    logic          w_clr;
    logic          w_inc;
    logic          w_last;
    logic [n-1:0]  w_sr_next;

    // start always opens a fresh frame, so it always clears the count.
    // A bit only counts in SHIFT, and start on the same edge drops it.
    assign w_clr  = start;
    assign w_inc  = (r_state == SHIFT) && !start && sin_valid;
    assign w_last = (w_count == CW'(n - 1));

    bit_counter #(.n(n)) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_count (w_count)
    );

    // Next shift-register value: MSB-first shifts left so the first bit
    // ends in Q[n-1]; LSB-first shifts right so it ends in Q[0].
    always_comb begin
        w_sr_next = r_sr;
        if (MSB_FIRST != 0) begin
            w_sr_next = {r_sr[n-2:0], sin};
        end else begin
            w_sr_next = {sin, r_sr[n-1:1]};
        end
    end

    // Frame FSM with registered outputs; load and abort default low so they
    // are single-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_q     <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_load  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_sr    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // Restart: throw away the partial frame, Q untouched.
                        r_sr    <= '0;
                        r_abort <= 1'b1;
                    end else if (sin_valid) begin
                        r_sr <= w_sr_next;
                        if (w_last) begin
                            r_state <= LOAD;
                            r_q     <= w_sr_next;
                            r_load  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_sr    <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Q     = r_q;
    assign load  = r_load;
    assign busy  = r_busy;
    assign abort = r_abort;

endmodule

// File: tb/tb_sipo_loader.sv
// Directed bench for sipo_loader: two n=4 instances (MSB-first and
// LSB-first) share one stimulus stream; expected words are hand-computed.
module tb_sipo_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       sin;
    logic       sin_valid;
    logic [3:0] q_msb, q_lsb;
    logic       load_msb, load_lsb;
    logic       busy_msb, busy_lsb;
    logic       abort_msb, abort_lsb;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    sipo_loader #(.n(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .start(start), .sin(sin), .sin_valid(sin_valid),
        .Q(q_msb), .load(load_msb), .busy(busy_msb), .abort(abort_msb)
    );

    sipo_loader #(.n(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .start(start), .sin(sin), .sin_valid(sin_valid),
        .Q(q_lsb), .load(load_lsb), .busy(busy_lsb), .abort(abort_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    // Check both instances' control outputs at once.
    task automatic check_ctl(input string tag, input logic ld, input logic bz, input logic ab);
        check({tag, "_load_m"},  32'(load_msb),  32'(ld));
        check({tag, "_load_l"},  32'(load_lsb),  32'(ld));
        check({tag, "_busy_m"},  32'(busy_msb),  32'(bz));
        check({tag, "_busy_l"},  32'(busy_lsb),  32'(bz));
        check({tag, "_abort_m"}, 32'(abort_msb), 32'(ab));
        check({tag, "_abort_l"}, 32'(abort_lsb), 32'(ab));
    endtask

    task automatic check_q(input string tag, input logic [3:0] em, input logic [3:0] el);
        check({tag, "_q_m"}, 32'(q_msb), 32'(em));
        check({tag, "_q_l"}, 32'(q_lsb), 32'(el));
    endtask

    initial begin
        logic [3:0] bits_a;
        int         gaps [4];

        reset = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        tick(); tick();
        check_ctl("rst", 1'b0, 1'b0, 1'b0);
        check_q("rst", 4'b0000, 4'b0000);
        reset = 1'b0;
        tick();

        // sin_valid in IDLE is ignored
        sin = 1'b1; sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0; sin = 1'b0;
        check_ctl("idle_ign", 1'b0, 1'b0, 1'b0);

        // Basic frame 1,0,1,1
        do_start();
        check_ctl("f1_start", 1'b0, 1'b1, 1'b0);
        bits_a = 4'b1011;
        for (int i = 3; i >= 1; i--) begin
            send_bit(bits_a[i]);
            check_ctl("f1_mid", 1'b0, 1'b1, 1'b0);
        end
        send_bit(bits_a[0]);
        check_ctl("f1_load", 1'b1, 1'b0, 1'b0);
        check_q("f1_load", 4'b1011, 4'b1101);
        tick();
        check_ctl("f1_after", 1'b0, 1'b0, 1'b0);
        check_q("f1_hold", 4'b1011, 4'b1101);

        // Same bits with gaps 0,3,2 after bits 1..3: load after 4+5 edges
        gaps = '{0, 3, 2, 0};
        do_start();
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            send_bit(bits_a[3-i]);
            cyc++;
            if (i < 3) begin
                check_ctl("gap_bit", 1'b0, 1'b1, 1'b0);
                for (int g = 0; g < gaps[i]; g++) begin
                    tick();
                    cyc++;
                    check_ctl("gap_idle", 1'b0, 1'b1, 1'b0);
                end
            end
        end
        check("gap_latency", 32'(cyc), 32'd9);
        check_ctl("gap_load", 1'b1, 1'b0, 1'b0);
        check_q("gap_load", 4'b1011, 4'b1101);
        tick();

        // Restart after 2 bits; restart edge also carries a valid bit (dropped)
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
        check_ctl("rs_abort", 1'b0, 1'b1, 1'b1);
        check_q("rs_keep", 4'b1011, 4'b1101);
        send_bit(1'b0);
        check_ctl("rs_b1", 1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check_ctl("rs_b3", 1'b0, 1'b1, 1'b0);
        send_bit(1'b0);
        check_ctl("rs_load", 1'b1, 1'b0, 1'b0);
        check_q("rs_load", 4'b0110, 4'b0110);
        tick();

        // Asynchronous reset after 3 bits
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        #1;
        check_ctl("ar_now", 1'b0, 1'b0, 1'b0);
        check_q("ar_now", 4'b0000, 4'b0000);
        tick();
        check_ctl("ar_hold", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_ctl("ar_idle", 1'b0, 1'b0, 1'b0);
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        check_ctl("ar_load", 1'b1, 1'b0, 1'b0);
        check_q("ar_load", 4'b1100, 4'b0011);
        tick();

        // Back-to-back: 1111 then start in LOAD, then 0001
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check_ctl("bb_load1", 1'b1, 1'b0, 1'b0);
        check_q("bb_load1", 4'b1111, 4'b1111);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_ctl("bb_restart", 1'b0, 1'b1, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check_ctl("bb_mid", 1'b0, 1'b1, 1'b0);
        check_q("bb_mid", 4'b1111, 4'b1111);
        send_bit(1'b1);
        check_ctl("bb_load2", 1'b1, 1'b0, 1'b0);
        check_q("bb_load2", 4'b0001, 4'b1000);
        tick();
        check_ctl("bb_idle", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
